ft601_fifo_emulator: RTL

- Synthesizable model of the FT601 chip side of the 245 synchronous FIFO bus: it is the responder to our FT601 controller.
- Two internal buffers:
  - RX: host to FPGA, drained by controller reads.
  - TX: FPGA to host, filled by controller writes.
- Drives usb_rx_empty and usb_tx_full, and reacts to usb_rden_l, usb_outen_l, usb_wren_l and usb_rst_l.
- Used for on-chip loopback and bring-up without a USB host. The host side is a pair of valid/ready streams.

---
 rtl/ft601_pkg.sv | 14 +
 rtl/sync_fifo.sv | 70 +++++++
 rtl/ft601_fifo_emulator.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ft601_pkg.sv
// Shared widths and the word format carried through both emulator buffers.
// The byte enables sit above the data so a packed word matches the host {be, data} stream layout.
package ft601_pkg;

  localparam int FT601_DATA_W = 32;
  localparam int FT601_BE_W   = 4;
  localparam int FT601_WORD_W = FT601_DATA_W + FT601_BE_W;

  typedef struct packed {
    logic [FT601_BE_W-1:0]   be;
    logic [FT601_DATA_W-1:0] data;
  } ft601_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through output, occupancy count and a synchronous flush.
// o_count_next lets the owner register its own flags without a stale cycle.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 36
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_din,
  output logic [WIDTH-1:0]           o_dout,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic [$clog2(DEPTH+1)-1:0] o_count_next,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  // A push into a full buffer is only legal when the same edge frees a slot.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_comb begin
    o_count_next = r_count;
    if (i_flush)
      o_count_next = '0;
    else if (w_push && !w_pop)
      o_count_next = r_count + CW'(1);
    else if (!w_push && w_pop)
      o_count_next = r_count - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= o_count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush)
      r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/ft601_fifo_emulator.sv
// FT601 chip-side responder for the 245 synchronous FIFO bus: RX feeds controller reads from the host,
// TX collects controller writes for the host, with sticky protocol error flags.
module ft601_fifo_emulator
  import ft601_pkg::*;
#(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          usb_rst_l,
  input  logic                          usb_wren_l,
  input  logic                          usb_rden_l,
  input  logic                          usb_outen_l,
  output logic                          usb_tx_full,
  output logic                          usb_rx_empty,
  input  logic [31:0]                   data_from_ctrl,
  input  logic [3:0]                    be_from_ctrl,
  output logic [31:0]                   data_to_ctrl,
  output logic [3:0]                    be_to_ctrl,
  output logic                          data_oe,
  input  logic [35:0]                   host_rx_data,
  input  logic                          host_rx_valid,
  output logic                          host_rx_ready,
  output logic [35:0]                   host_tx_data,
  output logic                          host_tx_valid,
  input  logic                          host_tx_ready,
  output logic [$clog2(RX_DEPTH+1)-1:0] rx_level,
  output logic [$clog2(TX_DEPTH+1)-1:0] tx_level,
  output logic                          err_underrun,
  output logic                          err_overflow,
  output logic                          err_bus_conflict
);

  localparam int RX_CW = $clog2(RX_DEPTH + 1);
  localparam int TX_CW = $clog2(TX_DEPTH + 1);

  ft601_word_t      w_rx_head;
  ft601_word_t      w_tx_head;
  ft601_word_t      w_rx_in;
  ft601_word_t      w_tx_in;
  logic [RX_CW-1:0] w_rx_count_next;
  logic [TX_CW-1:0] w_tx_count_next;
  logic             w_rx_full;
  logic             w_rx_empty;
  logic             w_tx_full;
  logic             w_tx_empty;
  logic             w_rx_push;
  logic             w_rx_pop;
  logic             w_tx_push;
  logic             w_tx_pop;
  logic             w_flush;
  logic             r_rx_empty;
  logic             r_tx_full;
  logic             r_data_oe;
  logic             r_err_underrun;
  logic             r_err_overflow;
  logic             r_err_conflict;

  assign w_flush   = ~usb_rst_l;
  assign w_rx_in   = ft601_word_t'(host_rx_data);
  assign w_tx_in   = '{be: be_from_ctrl, data: data_from_ctrl};

  assign host_rx_ready = usb_rst_l & ~w_rx_full;
  assign host_tx_valid = ~w_tx_empty;
  assign host_tx_data  = w_tx_head;

  assign w_rx_push = host_rx_valid & host_rx_ready;
  assign w_rx_pop  = usb_rst_l & ~usb_outen_l & ~usb_rden_l & ~r_rx_empty;
  assign w_tx_pop  = host_tx_valid & host_tx_ready;
  // r_tx_full also covers the post-reset cycle where the flag is held high over an empty buffer.
  assign w_tx_push = usb_rst_l & ~usb_wren_l & ((~r_tx_full & ~w_tx_full) | w_tx_pop);

  sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(FT601_WORD_W)) u_rx_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (w_flush),
    .i_push       (w_rx_push),
    .i_pop        (w_rx_pop),
    .i_din        (w_rx_in),
    .o_dout       (w_rx_head),
    .o_count      (rx_level),
    .o_count_next (w_rx_count_next),
    .o_full       (w_rx_full),
    .o_empty      (w_rx_empty)
  );

  sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(FT601_WORD_W)) u_tx_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (w_flush),
    .i_push       (w_tx_push),
    .i_pop        (w_tx_pop),
    .i_din        (w_tx_in),
    .o_dout       (w_tx_head),
    .o_count      (tx_level),
    .o_count_next (w_tx_count_next),
    .o_full       (w_tx_full),
    .o_empty      (w_tx_empty)
  );

  // Flags come from next-state counts so a push or pop shows on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_empty     <= 1'b1;
      r_tx_full      <= 1'b1;
      r_data_oe      <= 1'b0;
      r_err_underrun <= 1'b0;
      r_err_overflow <= 1'b0;
      r_err_conflict <= 1'b0;
    end else if (!usb_rst_l) begin
      r_rx_empty     <= 1'b1;
      r_tx_full      <= 1'b1;
      r_data_oe      <= 1'b0;
      r_err_underrun <= 1'b0;
      r_err_overflow <= 1'b0;
      r_err_conflict <= 1'b0;
    end else begin
      r_rx_empty <= (w_rx_count_next == '0);
      r_tx_full  <= (w_tx_count_next == TX_CW'(TX_DEPTH));
      r_data_oe  <= ~usb_outen_l;
      if (!usb_rden_l && r_rx_empty) r_err_underrun <= 1'b1;
      if (!usb_wren_l && !w_tx_push) r_err_overflow <= 1'b1;
      if (!usb_wren_l && !usb_outen_l) r_err_conflict <= 1'b1;
    end
  end

  assign usb_rx_empty     = r_rx_empty;
  assign usb_tx_full      = r_tx_full;
  assign data_oe          = r_data_oe;
  assign data_to_ctrl     = (r_data_oe && !w_rx_empty) ? w_rx_head.data : '0;
  assign be_to_ctrl       = (r_data_oe && !w_rx_empty) ? w_rx_head.be : '0;
  assign err_underrun     = r_err_underrun;
  assign err_overflow     = r_err_overflow;
  assign err_bus_conflict = r_err_conflict;

endmodule
